// File: rtl/response_controller_pkg.sv
// Shared definitions for the SD response controller: FSM encoding,
// 48-bit response frame field positions and the CRC7 generator polynomial.
package response_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RESP = 2'd1,
        ST_CHECK     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam int START_BIT = 47;
    localparam int TX_BIT    = 46;
    localparam int INDEX_MSB = 45;
    localparam int INDEX_LSB = 40;
    localparam int ARG_MSB   = 39;
    localparam int ARG_LSB   = 8;
    localparam int CRC_MSB   = 7;
    localparam int CRC_LSB   = 1;
    localparam int END_BIT   = 0;

    // CRC covers start bit through the argument, i.e. frame bits [47:8]
    localparam int          CRC_DATA_WIDTH = START_BIT - ARG_LSB + 1;
    localparam logic [6:0]  CRC7_POLY      = 7'h09;

endpackage

// File: rtl/crc7_check.sv
// Combinational CRC7 (x^7 + x^3 + 1, initial value 0) over a 40-bit field,
// processed MSB first as the bits appear on the SD command line.
module crc7_check
    import response_controller_pkg::*;
(
    input  logic [CRC_DATA_WIDTH-1:0] data_i,
    output logic [6:0]                crc_o
);

    logic [6:0] crc;
    logic       feedback;

    always_comb begin
        crc      = '0;
        feedback = 1'b0;
        for (int i = CRC_DATA_WIDTH - 1; i >= 0; i--) begin
            feedback = data_i[i] ^ crc[6];
            crc      = {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
        crc_o = crc;
    end

endmodule

// File: rtl/response_controller.sv
// SD response phase controller: waits for the deserialized response word,
// checks index/framing/CRC, captures the argument and reports completion.
module response_controller
    import response_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RESP_WIDTH     = 48
) (
    input  logic                  iClock_SD,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic                  iRespExpected,
    input  logic [5:0]            iCmdIndex,
    input  logic [RESP_WIDTH-1:0] iParallel,
    input  logic                  iComplete,
    output logic                  oEnable,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [31:0]           oResponse,
    output logic                  oTimeoutErr,
    output logic                  oIndexErr,
    output logic                  oCrcErr,
    output logic                  oFrameErr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [RESP_WIDTH-1:0] word_q, word_d;
    logic [5:0]            index_q, index_d;
    logic [31:0]           response_q, response_d;
    logic                  enable_q, enable_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  index_err_q, index_err_d;
    logic                  crc_err_q, crc_err_d;
    logic                  frame_err_q, frame_err_d;
    logic [6:0]            crc_calc;

    crc7_check u_crc7_check (
        .data_i (word_q[START_BIT:ARG_LSB]),
        .crc_o  (crc_calc)
    );

    always_ff @(posedge iClock_SD or negedge iReset) begin
        if (!iReset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            word_q        <= '0;
            index_q       <= '0;
            response_q    <= '0;
            enable_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            index_err_q   <= 1'b0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            word_q        <= word_d;
            index_q       <= index_d;
            response_q    <= response_d;
            enable_q      <= enable_d;
            timeout_err_q <= timeout_err_d;
            index_err_q   <= index_err_d;
            crc_err_q     <= crc_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        word_d        = word_q;
        index_d       = index_q;
        response_d    = response_q;
        timeout_err_d = timeout_err_q;
        index_err_d   = index_err_q;
        crc_err_d     = crc_err_q;
        frame_err_d   = frame_err_q;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    index_d       = iCmdIndex;
                    timeout_err_d = 1'b0;
                    index_err_d   = 1'b0;
                    crc_err_d     = 1'b0;
                    frame_err_d   = 1'b0;
                    count_d       = '0;
                    state_d       = iRespExpected ? ST_WAIT_RESP : ST_DONE;
                end
            end
            ST_WAIT_RESP: begin
                count_d = count_q + 1'b1;
                // A word arriving on the last allowed cycle still counts as a response
                if (iComplete) begin
                    word_d  = iParallel;
                    state_d = ST_CHECK;
                end else if (count_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_CHECK: begin
                index_err_d = word_q[INDEX_MSB:INDEX_LSB] != index_q;
                frame_err_d = word_q[START_BIT] | word_q[TX_BIT] | ~word_q[END_BIT];
                crc_err_d   = word_q[CRC_MSB:CRC_LSB] != crc_calc;
                response_d  = word_q[ARG_MSB:ARG_LSB];
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        enable_d = (state_d == ST_WAIT_RESP);
    end

    assign oEnable     = enable_q;
    assign oBusy       = (state_q != ST_IDLE);
    assign oDone       = (state_q == ST_DONE);
    assign oResponse   = response_q;
    assign oTimeoutErr = timeout_err_q;
    assign oIndexErr   = index_err_q;
    assign oCrcErr     = crc_err_q;
    assign oFrameErr   = frame_err_q;

endmodule

// File: tb/tb_response_controller.sv
// Self-checking bench for response_controller: directed scenarios plus
// randomized transactions scored against a frame-level reference model.
module tb_response_controller;

    localparam int T = 64;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        resp_expected;
    logic [5:0]  cmd_index;
    logic [47:0] parallel;
    logic        complete;
    logic        enable;
    logic        busy;
    logic        done;
    logic [31:0] response;
    logic        timeout_err;
    logic        index_err;
    logic        crc_err;
    logic        frame_err;

    int total_checks;
    int bad_checks;

    logic [31:0] exp_resp;
    logic        exp_to;
    logic        exp_idx;
    logic        exp_crc;
    logic        exp_frame;

    response_controller #(.TIMEOUT_CYCLES(T), .RESP_WIDTH(48)) dut (
        .iClock_SD     (clk),
        .iReset        (rst_n),
        .iStart        (start),
        .iRespExpected (resp_expected),
        .iCmdIndex     (cmd_index),
        .iParallel     (parallel),
        .iComplete     (complete),
        .oEnable       (enable),
        .oBusy         (busy),
        .oDone         (done),
        .oResponse     (response),
        .oTimeoutErr   (timeout_err),
        .oIndexErr     (index_err),
        .oCrcErr       (crc_err),
        .oFrameErr     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (0x89)
    function automatic logic [6:0] ref_crc7(input logic [39:0] data);
        logic [46:0] rem;
        logic [46:0] divisor;
        rem = {data, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (rem[i]) begin
                divisor = 47'h89 << (i - 7);
                rem     = rem ^ divisor;
            end
        end
        return rem[6:0];
    endfunction

    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b00, idx, arg};
        return {head, ref_crc7(head), 1'b1};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic check_status(input string tag);
        checkOutput({tag, "_resp"}, 64'(response), 64'(exp_resp));
        checkOutput({tag, "_to"}, 64'(timeout_err), 64'(exp_to));
        checkOutput({tag, "_idx"}, 64'(index_err), 64'(exp_idx));
        checkOutput({tag, "_crc"}, 64'(crc_err), 64'(exp_crc));
        checkOutput({tag, "_frm"}, 64'(frame_err), 64'(exp_frame));
    endtask

    task automatic model_clear();
        exp_to    = 1'b0;
        exp_idx   = 1'b0;
        exp_crc   = 1'b0;
        exp_frame = 1'b0;
    endtask

    // Expected outcome of a received frame, straight from the field rules
    task automatic model_frame(input logic [47:0] frame, input logic [5:0] idx);
        exp_idx   = frame[45:40] != idx;
        exp_frame = (frame[47] != 1'b0) || (frame[46] != 1'b0) || (frame[0] != 1'b1);
        exp_crc   = frame[7:1] != ref_crc7(frame[47:8]);
        exp_resp  = frame[39:8];
    endtask

    // delay = cycles after WAIT_RESP entry at which iComplete is presented
    task automatic applyStimulus(input string tag, input bit resp_exp, input logic [5:0] idx,
                                 input logic [47:0] frame, input int delay, input bit no_complete);
        @(negedge clk);
        start         = 1'b1;
        resp_expected = resp_exp;
        cmd_index     = idx;
        @(negedge clk);
        start         = 1'b0;
        resp_expected = 1'($urandom);
        cmd_index     = 6'($urandom);
        model_clear();
        if (!resp_exp) begin
            checkOutput({tag, "_nr_done"}, 64'(done), 64'd1);
            checkOutput({tag, "_nr_en"}, 64'(enable), 64'd0);
            check_status({tag, "_nr"});
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput({tag, "_nr_busy"}, 64'(busy), 64'd0);
            checkOutput({tag, "_nr_done2"}, 64'(done), 64'd0);
            checkOutput({tag, "_nr_en2"}, 64'(enable), 64'd0);
            return;
        end
        checkOutput({tag, "_en"}, 64'(enable), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
        check_status({tag, "_clr"});
        if (no_complete) begin
            for (int k = 1; k <= T; k++) begin
                start         = (k == 3);
                resp_expected = 1'b0;
                parallel      = {16'($urandom), 32'($urandom)};
                @(negedge clk);
                if (k == T - 1) begin
                    checkOutput({tag, "_to_early"}, 64'(done), 64'd0);
                    checkOutput({tag, "_to_en"}, 64'(enable), 64'd1);
                end
            end
            start  = 1'b0;
            exp_to = 1'b1;
            checkOutput({tag, "_to_done"}, 64'(done), 64'd1);
            checkOutput({tag, "_to_en_off"}, 64'(enable), 64'd0);
            check_status({tag, "_to"});
            @(negedge clk);
            checkOutput({tag, "_to_done_off"}, 64'(done), 64'd0);
            checkOutput({tag, "_to_idle_en"}, 64'(enable), 64'd0);
            return;
        end
        for (int k = 0; k < delay; k++) begin
            start         = 1'($urandom);
            resp_expected = 1'b0;
            parallel      = {16'($urandom), 32'($urandom)};
            @(negedge clk);
        end
        start    = 1'b0;
        complete = 1'b1;
        parallel = frame;
        @(negedge clk);
        complete = 1'b0;
        parallel = {16'($urandom), 32'($urandom)};
        checkOutput({tag, "_chk_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_chk_en"}, 64'(enable), 64'd0);
        @(negedge clk);
        model_frame(frame, idx);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        check_status(tag);
        complete = 1'b1;
        @(negedge clk);
        complete = 1'b0;
        checkOutput({tag, "_done_off"}, 64'(done), 64'd0);
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
        @(negedge clk);
        check_status({tag, "_hold"});
    endtask

    initial begin
        logic [47:0] frame;
        logic [5:0]  idx;
        logic [31:0] arg;
        int          kind;

        total_checks  = 0;
        bad_checks    = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        resp_expected = 1'b0;
        cmd_index     = '0;
        parallel      = '0;
        complete      = 1'b0;
        exp_resp      = '0;
        model_clear();

        #1;
        checkOutput("rst_en", 64'(enable), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        check_status("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("good", 1'b1, 6'd17, build_frame(6'd17, 32'h0000_0900), 4, 1'b0);
        applyStimulus("idxerr", 1'b1, 6'd17, build_frame(6'd18, 32'h0000_0900), 4, 1'b0);
        applyStimulus("timeout", 1'b1, 6'd17, '0, 0, 1'b1);
        frame = build_frame(6'd17, 32'h0000_0900);
        frame[1] = ~frame[1];
        applyStimulus("crcerr", 1'b1, 6'd17, frame, 4, 1'b0);
        frame = build_frame(6'd17, 32'h0000_0A55);
        frame[0] = 1'b0;
        applyStimulus("enderr", 1'b1, 6'd17, frame, 4, 1'b0);
        applyStimulus("noresp", 1'b0, 6'd5, '0, 0, 1'b0);
        applyStimulus("lastcyc", 1'b1, 6'd3, build_frame(6'd3, 32'hDEAD_BEEF), T - 1, 1'b0);
        applyStimulus("firstcyc", 1'b1, 6'd9, build_frame(6'd9, 32'h1234_5678), 0, 1'b0);

        @(negedge clk);
        start         = 1'b1;
        resp_expected = 1'b1;
        cmd_index     = 6'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_resp = '0;
        model_clear();
        checkOutput("midrst_en", 64'(enable), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        check_status("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postrst", 1'b1, 6'd17, build_frame(6'd17, 32'h0000_0900), 4, 1'b0);

        for (int n = 0; n < 16; n++) begin
            idx   = 6'($urandom);
            arg   = $urandom;
            frame = build_frame(idx, arg);
            kind  = int'($urandom_range(0, 5));
            case (kind)
                1: frame = build_frame(idx + 6'd1, arg);
                2: frame[$urandom_range(1, 7)] ^= 1'b1;
                3: begin
                    case ($urandom_range(0, 2))
                        0: frame[47] = 1'b1;
                        1: frame[46] = 1'b1;
                        default: frame[0] = 1'b0;
                    endcase
                end
                4: frame = {16'($urandom), 32'($urandom)};
                default: ;
            endcase
            applyStimulus($sformatf("rnd%0d", n), kind != 5, idx, frame,
                          int'($urandom_range(0, 12)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/response_controller.md
RESPONSE_CONTROLLER -- requirements
Module: response_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum iClock_SD cycles to wait for a response before flagging timeout.
REQ-002 SHALL have parameter RESP_WIDTH, default 48: deserializer word width.
REQ-003 SHALL have port iClock_SD  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port iReset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iStart  input  1  one-cycle request: command sent, begin response phase.
REQ-006 SHALL have port iRespExpected  input  1  sampled with iStart: 1 = 48-bit response expected, 0 = no response.
REQ-007 SHALL have port iCmdIndex  input  6  sampled with iStart: expected response command index.
REQ-008 SHALL have port iParallel  input  RESP_WIDTH  word from the serial_parallel deserializer.
REQ-009 SHALL have port iComplete  input  1  deserializer word-complete flag.
REQ-010 SHALL have port oEnable  output  1  enable to the deserializer.
REQ-011 SHALL have port oBusy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port oDone  output  1  one-cycle pulse: response phase finished.
REQ-013 SHALL have port oResponse  output  32  captured argument field iParallel[39:8].
REQ-014 SHALL have port oTimeoutErr, oIndexErr, oCrcErr, oFrameErr  output  1 each  status flags.

Function
REQ-015 SHALL implement states IDLE, WAIT_RESP, CHECK, DONE.
REQ-016 IDLE: iStart=1 with iRespExpected=1 SHALL go to WAIT_RESP, clear all error flags, and zero the timeout counter.
REQ-017 IDLE: iStart=1 with iRespExpected=0 SHALL go directly to DONE, clear error flags, and leave oResponse unchanged.
REQ-018 oEnable SHALL be 1 exactly while in WAIT_RESP (registered; asserted the cycle after iStart).
REQ-019 WAIT_RESP: the counter SHALL increment each cycle; iComplete=1 SHALL register iParallel and go to CHECK.
REQ-020 WAIT_RESP: counter reaching TIMEOUT_CYCLES-1 with iComplete=0 SHALL set oTimeoutErr and go to DONE.
REQ-021 iComplete and timeout in the same cycle: iComplete SHALL win (no timeout flag).
REQ-022 CHECK (one cycle) SHALL set the following flags:
  - oIndexErr when captured [45:40] != iCmdIndex latched at start.
  - oFrameErr when [47]!=0, [46]!=0 or [0]!=1.
  - oCrcErr when [7:1] != CRC7(x^7+x^3+1, init 0) over [47:8].
REQ-023 CHECK SHALL load oResponse=[39:8] regardless of errors, then go to DONE.
REQ-024 DONE SHALL assert oDone for exactly one cycle and return to IDLE.
REQ-025 Latency SHALL be: iComplete in cycle N -> CHECK at N+1 -> oDone at N+2; no-response path: iStart at N -> oDone at N+1.
REQ-026 iStart outside IDLE SHALL be ignored.
REQ-027 iComplete outside WAIT_RESP SHALL be ignored.
REQ-028 Error flags and oResponse SHALL hold their values until the next accepted iStart.

Reset
REQ-029 iReset=0 SHALL asynchronously force IDLE, counter 0, oEnable=0, oBusy=0, oDone=0, oResponse=0, and all error flags 0.
REQ-030 Reset mid-WAIT_RESP SHALL drop oEnable immediately; the captured word SHALL be discarded.
REQ-031 After reset deassertion, the first iStart SHALL be accepted normally.

Structure
REQ-032 The shared package SHALL hold the state encoding, response field bit positions (start, tx, index, arg, crc, end), and the CRC7 polynomial constant.
REQ-033 CRC7 SHALL be a combinational sub-module crc7_check (40-bit data in, 7-bit CRC out); the FSM and counter SHALL stay in response_controller.
REQ-034 The counter width SHALL be clog2(TIMEOUT_CYCLES).

Verification
REQ-035 Bench SHALL drive iStart, iRespExpected=1, iCmdIndex=17, then a valid frame (index 17, arg 0x00000900, bench-computed CRC, end 1) with iComplete 5 cycles later -> oDone 2 cycles after iComplete, oResponse=0x00000900, all flags 0.
REQ-036 Same stimulus with the frame's index field=18 -> oIndexErr=1, others 0, oResponse still loaded.
REQ-037 No iComplete -> oTimeoutErr=1 and oDone on cycle TIMEOUT_CYCLES after WAIT_RESP entry; oEnable low thereafter.
REQ-038 CRC bit [1] flipped -> oCrcErr=1; end bit [0]=0 -> oFrameErr=1.
REQ-039 iRespExpected=0 -> oDone the next cycle, oEnable never high; iStart repeated while busy -> no effect.
REQ-040 iReset=0 pulse during WAIT_RESP -> oEnable=0 and oBusy=0 asynchronously; subsequent valid transaction passes.
